// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle RV32 control unit.
// Holds the FSM state encoding (visible on the debug "state" port), the
// supported opcode values, the ALU operation codes and the ALU operand-B
// select codes driven by multicycle_control.
package control_pkg;

    // Encoding is exported on the 4-bit debug port, so values are fixed.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_ALU   = 4'd3,
        MEM_ADDR = 4'd4,
        LOAD     = 4'd5,
        WB_MEM   = 4'd6,
        STORE    = 4'd7,
        BRANCH   = 4'd8,
        ERROR    = 4'd9
    } state_t;

    // Supported RV32 major opcodes (instruction[6:0]).
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // ALU operation requests.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU operand-B selects.
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational opcode classifier for the multi-cycle control unit.
// Ports:
//   opcode      in   instruction[6:0]
//   is_r        out  R-type ALU instruction
//   is_load     out  load
//   is_store    out  store
//   is_beq      out  conditional branch (BEQ)
//   is_illegal  out  any opcode not listed above
// Exactly one output is high for every opcode value.
module opcode_decode
    import control_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_r,
    output logic       is_load,
    output logic       is_store,
    output logic       is_beq,
    output logic       is_illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves a variable unassigned, which would infer a latch.
        is_r       = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_beq     = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_R:     is_r       = 1'b1;
            OP_LOAD:  is_load    = 1'b1;
            OP_STORE: is_store   = 1'b1;
            OP_BEQ:   is_beq     = 1'b1;
            default:  is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style sequencer for the multi-cycle RV32 datapath (shared memory,
// IR, single ALU, register file, PC). Handles R-type, load, store and BEQ,
// with a stall timeout on every memory-wait state, a retired-instruction
// counter and sticky illegal/timeout flags.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instruction[31:0]        IR contents, valid from DECODE onward
//   mem_ready                memory completes the current access this cycle
//   pc_write, pc_write_cond  PC load (unconditional / qualified by ALU zero)
//   pc_src                   0 = ALU result, 1 = branch target adder
//   ir_write                 IR load
//   iord                     memory address: 0 = PC, 1 = ALU result register
//   mem_read, mem_write      memory requests
//   mem_reg                  writeback data: 1 = memory, 0 = ALU
//   reg_write                register file write enable
//   alu_src_a                0 = PC, 1 = rs1
//   alu_src_b[1:0]           00 = rs2, 01 = 4, 10 = immediate
//   ALU_op[1:0]              00 add, 01 subtract, 10 funct-decoded
//   state[3:0]               current state (debug)
//   illegal, timeout         sticky error flags
//   instr_retired            retired instruction count (wraps)
module multicycle_control
    import control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instruction,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               pc_src,
    output logic               ir_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         ALU_op,
    output logic [3:0]         state,
    output logic               illegal,
    output logic               timeout,
    output logic [COUNT_W-1:0] instr_retired
);

    // Stall counter only has to reach MEM_TIMEOUT; it saturates at all-ones.
    localparam int                  STALL_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [STALL_W-1:0]  STALL_LIMIT = STALL_W'(MEM_TIMEOUT);

    state_t               cur_state;
    state_t               nxt_state;
    logic [STALL_W-1:0]   stall_cnt;
    logic                 is_r, is_load, is_store, is_beq, is_illegal;
    logic                 in_wait;
    logic                 timeout_hit;
    logic                 retire;
    logic                 set_illegal;
    logic                 set_timeout;

    // Only the major opcode steers the sequencer; the rest is datapath's.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction[31:7];

    opcode_decode u_decode (
        .opcode     (instruction[6:0]),
        .is_r       (is_r),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_beq     (is_beq),
        .is_illegal (is_illegal)
    );

    assign state   = cur_state;
    assign in_wait = (cur_state == FETCH) || (cur_state == LOAD) || (cur_state == STORE);

    // A completing access (mem_ready) always takes priority over the timeout.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (stall_cnt == STALL_LIMIT);

    always_comb begin
        nxt_state     = cur_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_reg       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_RS2;
        ALU_op        = ALU_ADD;
        retire        = 1'b0;
        set_illegal   = 1'b0;
        set_timeout   = 1'b0;

        case (cur_state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                // IR and PC+4 are captured on the same edge the fetch completes.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    nxt_state = DECODE;
                end else if (timeout_hit) begin
                    nxt_state   = ERROR;
                    set_timeout = 1'b1;
                end
            end
            DECODE: begin
                if (is_r) begin
                    nxt_state = EXEC_R;
                end else if (is_load || is_store) begin
                    nxt_state = MEM_ADDR;
                end else if (is_beq) begin
                    nxt_state = BRANCH;
                end else begin
                    nxt_state   = ERROR;
                    set_illegal = is_illegal;
                end
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_RS2;
                ALU_op    = ALU_FUNCT;
                nxt_state = WB_ALU;
            end
            WB_ALU: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                nxt_state = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                nxt_state = is_load ? LOAD : STORE;
            end
            LOAD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    nxt_state = WB_MEM;
                end else if (timeout_hit) begin
                    nxt_state   = ERROR;
                    set_timeout = 1'b1;
                end
            end
            WB_MEM: begin
                reg_write = 1'b1;
                mem_reg   = 1'b1;
                retire    = 1'b1;
                nxt_state = FETCH;
            end
            STORE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    nxt_state = FETCH;
                end else if (timeout_hit) begin
                    nxt_state   = ERROR;
                    set_timeout = 1'b1;
                end
            end
            BRANCH: begin
                // Taken/not-taken is resolved in the datapath via ALU zero.
                alu_src_a     = 1'b1;
                alu_src_b     = SRC_B_RS2;
                ALU_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 1'b1;
                retire        = 1'b1;
                nxt_state     = FETCH;
            end
            ERROR: begin
                nxt_state = ERROR;
            end
            default: begin
                nxt_state = ERROR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            cur_state     <= FETCH;
            stall_cnt     <= '0;
            illegal       <= 1'b0;
            timeout       <= 1'b0;
            instr_retired <= '0;
        end else begin
            cur_state <= nxt_state;

            // Wait states are only ever entered from a different state, so
            // any state change is an entry and restarts the stall count.
            if (nxt_state != cur_state) begin
                stall_cnt <= '0;
            end else if (in_wait && !mem_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end

            if (set_illegal) illegal <= 1'b1;
            if (set_timeout) timeout <= 1'b1;

            if (retire) instr_retired <= instr_retired + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control, built with
// MEM_TIMEOUT=4 and COUNT_W=4 so timeout and counter wrap are reachable.
module tb_multicycle_control;

    localparam int MEM_TIMEOUT = 4;
    localparam int COUNT_W     = 4;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LW  = 32'h0000A183;
    localparam logic [31:0] I_SW  = 32'h0020A023;
    localparam logic [31:0] I_BEQ = 32'h00208463;
    localparam logic [31:0] I_BAD = 32'h0000007F;

    // Expected {state[3:0], pc_write, pc_write_cond, pc_src, ir_write, iord,
    //           mem_read, mem_write, mem_reg, reg_write, alu_src_a,
    //           alu_src_b[1:0], ALU_op[1:0]}
    localparam logic [17:0] E_FETCH_RDY = {4'd0, 14'b1_0_0_1_0_1_0_0_0_0_01_00};
    localparam logic [17:0] E_FETCH_STL = {4'd0, 14'b0_0_0_0_0_1_0_0_0_0_01_00};
    localparam logic [17:0] E_DECODE    = {4'd1, 14'b0_0_0_0_0_0_0_0_0_0_00_00};
    localparam logic [17:0] E_EXEC_R    = {4'd2, 14'b0_0_0_0_0_0_0_0_0_1_00_10};
    localparam logic [17:0] E_WB_ALU    = {4'd3, 14'b0_0_0_0_0_0_0_0_1_0_00_00};
    localparam logic [17:0] E_MEM_ADDR  = {4'd4, 14'b0_0_0_0_0_0_0_0_0_1_10_00};
    localparam logic [17:0] E_LOAD      = {4'd5, 14'b0_0_0_0_1_1_0_0_0_0_00_00};
    localparam logic [17:0] E_WB_MEM    = {4'd6, 14'b0_0_0_0_0_0_0_1_1_0_00_00};
    localparam logic [17:0] E_STORE     = {4'd7, 14'b0_0_0_0_1_0_1_0_0_0_00_00};
    localparam logic [17:0] E_BRANCH    = {4'd8, 14'b0_1_1_0_0_0_0_0_0_1_00_01};
    localparam logic [17:0] E_ERROR     = {4'd9, 14'b0};

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        instruction;
    logic               mem_ready;
    logic               pc_write, pc_write_cond, pc_src, ir_write, iord;
    logic               mem_read, mem_write, mem_reg, reg_write, alu_src_a;
    logic [1:0]         alu_src_b, ALU_op;
    logic [3:0]         state;
    logic               illegal, timeout;
    logic [COUNT_W-1:0] instr_retired;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .COUNT_W(COUNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .ir_write      (ir_write),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_reg       (mem_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .ALU_op        (ALU_op),
        .state         (state),
        .illegal       (illegal),
        .timeout       (timeout),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] observed();
        return {state, pc_write, pc_write_cond, pc_src, ir_write, iord,
                mem_read, mem_write, mem_reg, reg_write, alu_src_a,
                alu_src_b, ALU_op};
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1-2 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instruction = 32'h0;
        mem_ready = 1'b0;
        tick();
        tick();
        #1;
        n_cmp++;
        if (observed() !== E_FETCH_STL) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %h want %h", observed(), E_FETCH_STL);
        end
        n_cmp++;
        if ({illegal, timeout, instr_retired} !== {1'b0, 1'b0, {COUNT_W{1'b0}}}) begin
            n_bad++;
            $display("FAIL reset_flags: illegal=%b timeout=%b retired=%0d want 0 0 0",
                     illegal, timeout, instr_retired);
        end
        rst = 1'b0;
    endtask

    task automatic test_r_type();
        logic [17:0] exp [4] = '{E_FETCH_RDY, E_DECODE, E_EXEC_R, E_WB_ALU};
        instruction = I_ADD;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            n_cmp++;
            if (observed() !== exp[i]) begin
                n_bad++;
                $display("FAIL rtype_cyc%0d: got %h want %h", i + 1, observed(), exp[i]);
            end
            if (i == 3) begin
                n_cmp++;
                if (instr_retired !== 4'd0) begin
                    n_bad++;
                    $display("FAIL rtype_pre_retire: got %0d want 0", instr_retired);
                end
            end
            tick();
        end
        n_cmp++;
        if ({state, instr_retired} !== {4'd0, 4'd1}) begin
            n_bad++;
            $display("FAIL rtype_done: state=%0d retired=%0d want 0 1", state, instr_retired);
        end
    endtask

    task automatic test_load_stall();
        logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [17:0] exp [8] = '{E_FETCH_RDY, E_DECODE, E_MEM_ADDR, E_LOAD,
                                 E_LOAD, E_LOAD, E_LOAD, E_WB_MEM};
        instruction = I_LW;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            n_cmp++;
            if (observed() !== exp[i]) begin
                n_bad++;
                $display("FAIL load_cyc%0d: got %h want %h", i + 1, observed(), exp[i]);
            end
            tick();
        end
        n_cmp++;
        if ({state, instr_retired} !== {4'd0, 4'd2}) begin
            n_bad++;
            $display("FAIL load_done: state=%0d retired=%0d want 0 2", state, instr_retired);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_sw  [4] = '{E_FETCH_RDY, E_DECODE, E_MEM_ADDR, E_STORE};
        logic [17:0] exp_beq [3] = '{E_FETCH_RDY, E_DECODE, E_BRANCH};
        mem_ready = 1'b1;
        instruction = I_SW;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (observed() !== exp_sw[i]) begin
                n_bad++;
                $display("FAIL store_cyc%0d: got %h want %h", i + 1, observed(), exp_sw[i]);
            end
            tick();
        end
        instruction = I_BEQ;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (observed() !== exp_beq[i]) begin
                n_bad++;
                $display("FAIL beq_cyc%0d: got %h want %h", i + 1, observed(), exp_beq[i]);
            end
            tick();
        end
        n_cmp++;
        if ({state, instr_retired} !== {4'd0, 4'd4}) begin
            n_bad++;
            $display("FAIL sw_beq_done: state=%0d retired=%0d want 0 4", state, instr_retired);
        end
    endtask

    task automatic test_illegal();
        instruction = I_BAD;
        mem_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            instruction = (i == 5) ? I_ADD : I_BAD;
            #1;
            n_cmp++;
            if ({observed(), illegal, timeout} !== {E_ERROR, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL illegal_hold%0d: got %h il=%b to=%b want %h il=1 to=0",
                         i, observed(), illegal, timeout, E_ERROR);
            end
            tick();
        end
        do_reset();
        #1;
        n_cmp++;
        if ({observed(), illegal, instr_retired} !== {E_FETCH_STL, 1'b0, 4'd0}) begin
            n_bad++;
            $display("FAIL illegal_clear: got %h il=%b ret=%0d want %h il=0 ret=0",
                     observed(), illegal, instr_retired, E_FETCH_STL);
        end
    endtask

    task automatic test_timeout();
        // Stall through the full limit: ERROR after the 5th wait cycle.
        do_reset();
        instruction = I_ADD;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b0;
            #1;
            n_cmp++;
            if (observed() !== E_FETCH_STL) begin
                n_bad++;
                $display("FAIL timeout_stall%0d: got %h want %h", i + 1, observed(), E_FETCH_STL);
            end
            tick();
        end
        n_cmp++;
        if ({state, timeout, illegal} !== {4'd9, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL timeout_err: state=%0d to=%b il=%b want 9 1 0", state, timeout, illegal);
        end
        // Ready on the limit cycle wins.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 4);
            tick();
        end
        n_cmp++;
        if ({state, timeout} !== {4'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL timeout_ready_wins: state=%0d to=%b want 1 0", state, timeout);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        instruction = I_ADD;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        instruction = I_LW;
        for (int i = 0; i < 3; i++) tick();
        mem_ready = 1'b0;
        tick();
        #1;
        n_cmp++;
        if ({observed(), instr_retired} !== {E_LOAD, 4'd1}) begin
            n_bad++;
            $display("FAIL midload_pre: got %h ret=%0d want %h ret=1",
                     observed(), instr_retired, E_LOAD);
        end
        rst = 1'b1;
        tick();
        #1;
        n_cmp++;
        if ({observed(), instr_retired} !== {E_FETCH_STL, 4'd0}) begin
            n_bad++;
            $display("FAIL midload_rst: got %h ret=%0d want %h ret=0",
                     observed(), instr_retired, E_FETCH_STL);
        end
        rst = 1'b0;
    endtask

    task automatic test_retire_wrap();
        do_reset();
        instruction = I_BEQ;
        mem_ready = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            for (int c = 0; c < 3; c++) tick();
            if (n == 15) begin
                n_cmp++;
                if (instr_retired !== 4'd15) begin
                    n_bad++;
                    $display("FAIL wrap_15: got %0d want 15", instr_retired);
                end
            end
        end
        n_cmp++;
        if ({state, instr_retired, illegal, timeout} !== {4'd0, 4'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL wrap_0: state=%0d ret=%0d il=%b to=%b want 0 0 0 0",
                     state, instr_retired, illegal, timeout);
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load_stall();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid_load();
        test_retire_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
